// File: rtl/byte_ser_pkg.sv
// Shared constants, FSM state type and byte-order helpers for byte_serializer.
// Byte order is selected by BYTE_SER_MSB_FIRST_EN (undefined: LSB-first).
package byte_ser_pkg;

  localparam int unsigned NBYTES = 16;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned WORD_W = 128;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

`ifdef BYTE_SER_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] SEL_FIRST = 4'd15;
  localparam logic [SEL_W-1:0] SEL_LAST  = 4'd0;

  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
    return s - 4'd1;
  endfunction
`else
  localparam logic [SEL_W-1:0] SEL_FIRST = 4'd0;
  localparam logic [SEL_W-1:0] SEL_LAST  = 4'd15;

  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
    return s + 4'd1;
  endfunction
`endif

endpackage

// File: rtl/byte_serializer_mux.sv
// 128-to-8 byte mux: sel=0 picks in[7:0], sel=15 picks in[127:120].
module byte_serializer_mux
  import byte_ser_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic [7:0]        out
);

  always_comb begin
    out = in[{sel, 3'b000} +: 8];
  end

endmodule

// File: rtl/byte_serializer.sv
// Captures a 128-bit word over valid/ready and emits its 16 bytes with valid/ready/last.
// Byte order follows BYTE_SER_MSB_FIRST_EN (see byte_ser_pkg).
module byte_serializer
  import byte_ser_pkg::*;
#(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  if (NBYTES != byte_ser_pkg::NBYTES || SEL_W != byte_ser_pkg::SEL_W) begin : g_bad_param
    $error("byte_serializer: NBYTES must be 16 and SEL_W must be 4");
  end

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              at_last;

  byte_serializer_mux u_mux (
    .in  (word_q),
    .sel (sel_q),
    .out (out_data)
  );

  assign sel     = sel_q;
  assign at_last = (sel_q == SEL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  // in_ready follows out_ready combinationally on the last byte so the next
  // word loads on the same edge the final byte leaves: no bubble between words.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    sel_d     = sel_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_data;
          sel_d   = SEL_FIRST;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = at_last;
        in_ready  = at_last & out_ready;
        if (out_ready) begin
          if (!at_last) begin
            sel_d = sel_next(sel_q);
          end else if (in_valid) begin
            word_d = in_data;
            sel_d  = SEL_FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
